// File: rtl/morse_char_tx_pkg.sv
// ---------------------------------------------------------------------------
// morse_char_tx_pkg
// Shared Morse definitions: unit-count constants, the transmitter state
// encoding, the {len, pat} code record and the ASCII -> Morse lookup.
// The receive-side decoder uses the same lookup so both directions agree.
// ---------------------------------------------------------------------------
package morse_char_tx_pkg;

   // Durations in Morse units
   localparam logic [2:0] DOT_U      = 3'd1;
   localparam logic [2:0] DASH_U     = 3'd3;
   localparam logic [2:0] ELEM_GAP_U = 3'd1;
   localparam logic [2:0] CHAR_GAP_U = 3'd3;
   localparam logic [2:0] WORD_GAP_U = 3'd7;

   // pat is left-aligned, MSB first, 1 = dash, 0 = dot; len is 1..5
   typedef struct packed {
      logic [2:0] len;
      logic [4:0] pat;
   } morse_code_t;

   typedef struct packed {
      logic        valid;
      logic        is_space;
      morse_code_t code;
   } morse_lookup_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_MARK     = 3'd1,
      ST_ELEM_GAP = 3'd2,
      ST_CHAR_GAP = 3'd3,
      ST_WORD_GAP = 3'd4
   } tx_state_t;

   // Lower-case letters fold onto upper case; space is valid with no code.
   function automatic morse_lookup_t ascii_to_morse(input logic [7:0] c);
      morse_lookup_t r;
      logic [7:0]    u;
      if ((c >= 8'h61) && (c <= 8'h7A)) begin
         u = c - 8'h20;
      end else begin
         u = c;
      end
      r = {1'b1, 1'b0, 3'd0, 5'b00000};
      case (u)
         8'h41: r.code = {3'd2, 5'b01000}; // A .-
         8'h42: r.code = {3'd4, 5'b10000}; // B -...
         8'h43: r.code = {3'd4, 5'b10100}; // C -.-.
         8'h44: r.code = {3'd3, 5'b10000}; // D -..
         8'h45: r.code = {3'd1, 5'b00000}; // E .
         8'h46: r.code = {3'd4, 5'b00100}; // F ..-.
         8'h47: r.code = {3'd3, 5'b11000}; // G --.
         8'h48: r.code = {3'd4, 5'b00000}; // H ....
         8'h49: r.code = {3'd2, 5'b00000}; // I ..
         8'h4A: r.code = {3'd4, 5'b01110}; // J .---
         8'h4B: r.code = {3'd3, 5'b10100}; // K -.-
         8'h4C: r.code = {3'd4, 5'b01000}; // L .-..
         8'h4D: r.code = {3'd2, 5'b11000}; // M --
         8'h4E: r.code = {3'd2, 5'b10000}; // N -.
         8'h4F: r.code = {3'd3, 5'b11100}; // O ---
         8'h50: r.code = {3'd4, 5'b01100}; // P .--.
         8'h51: r.code = {3'd4, 5'b11010}; // Q --.-
         8'h52: r.code = {3'd3, 5'b01000}; // R .-.
         8'h53: r.code = {3'd3, 5'b00000}; // S ...
         8'h54: r.code = {3'd1, 5'b10000}; // T -
         8'h55: r.code = {3'd3, 5'b00100}; // U ..-
         8'h56: r.code = {3'd4, 5'b00010}; // V ...-
         8'h57: r.code = {3'd3, 5'b01100}; // W .--
         8'h58: r.code = {3'd4, 5'b10010}; // X -..-
         8'h59: r.code = {3'd4, 5'b10110}; // Y -.--
         8'h5A: r.code = {3'd4, 5'b11000}; // Z --..
         8'h30: r.code = {3'd5, 5'b11111}; // 0 -----
         8'h31: r.code = {3'd5, 5'b01111}; // 1 .----
         8'h32: r.code = {3'd5, 5'b00111}; // 2 ..---
         8'h33: r.code = {3'd5, 5'b00011}; // 3 ...--
         8'h34: r.code = {3'd5, 5'b00001}; // 4 ....-
         8'h35: r.code = {3'd5, 5'b00000}; // 5 .....
         8'h36: r.code = {3'd5, 5'b10000}; // 6 -....
         8'h37: r.code = {3'd5, 5'b11000}; // 7 --...
         8'h38: r.code = {3'd5, 5'b11100}; // 8 ---..
         8'h39: r.code = {3'd5, 5'b11110}; // 9 ----.
         8'h20: r.is_space = 1'b1;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/morse_char_tx_if.sv
// ---------------------------------------------------------------------------
// morse_char_tx_if
// Character-source handshake plus transmitter status.
//   char_code : ASCII character, sampled on an accepting edge
//   send      : request, accepted when send && ready
//   ready     : transmitter can take a character this cycle
//   busy      : transmission (or word gap) in progress
//   key_out   : Morse key, 1 = mark
//   done      : one-cycle pulse after the trailing gap
//   invalid   : one-cycle pulse after an unsupported character is accepted
// master = character source, slave = transmitter.
// ---------------------------------------------------------------------------
interface morse_char_tx_if;
   logic [7:0] char_code;
   logic       send;
   logic       ready;
   logic       busy;
   logic       key_out;
   logic       done;
   logic       invalid;

   modport master (
      output char_code, send,
      input  ready, busy, key_out, done, invalid
   );

   modport slave (
      input  char_code, send,
      output ready, busy, key_out, done, invalid
   );
endinterface

// File: rtl/morse_char_tx_unit_timer.sv
// ---------------------------------------------------------------------------
// morse_char_tx_unit_timer
// Down-counter measuring whole Morse units.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count to zero (abort)
//   load     : load units*UNIT_CYCLES-1
//   units    : duration in Morse units (1..7)
//   expired  : count reads zero; the owning state ends on this edge
// ---------------------------------------------------------------------------
module morse_char_tx_unit_timer #(
   parameter int unsigned UNIT_CYCLES = 32'd12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       load,
   input  logic [2:0] units,
   output logic       expired
);

   localparam int unsigned CW = $clog2(7 * UNIT_CYCLES);

   logic [CW-1:0] count_r;
   logic [CW-1:0] load_val_s;

   // Reload value: n units last n*UNIT_CYCLES cycles including the zero cycle
   always_comb begin
      load_val_s = (CW'(units) * CW'(UNIT_CYCLES)) - CW'(1);
   end

   // Count down to zero and hold there until reloaded
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= load_val_s;
      end else if (count_r != '0) begin
         count_r <= count_r - CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == '0);

endmodule

// File: rtl/morse_char_tx.sv
// ---------------------------------------------------------------------------
// morse_char_tx
// Accepts one ASCII character per handshake and keys it out as International
// Morse with standard unit timing (dot 1, dash 3, element gap 1, character
// gap 3, word gap 7 units).
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   en  : block enable; low aborts any transmission without a done pulse
//   bus : slave side of morse_char_tx_if (char_code/send in; ready, busy,
//         key_out, done, invalid out). ready is combinational, the rest
//         are registered.
// ---------------------------------------------------------------------------
module morse_char_tx
   import morse_char_tx_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES = 32'd12_500_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   morse_char_tx_if.slave   bus
);

   tx_state_t     state_r;
   logic [3:0]    tail_r;    // pattern bits still to send after the current element
   logic [2:0]    remain_r;  // elements left, including the one being keyed
   logic          key_out_r;
   logic          busy_r;
   logic          done_r;
   logic          invalid_r;

   morse_lookup_t lookup_s;
   logic          ready_s;
   logic          accept_s;
   logic          abort_s;
   logic          timer_load_s;
   logic          timer_clear_s;
   logic [2:0]    timer_units_s;
   logic          timer_expired_s;

   assign lookup_s = ascii_to_morse(bus.char_code);
   assign ready_s  = en && (state_r == ST_IDLE);
   assign accept_s = bus.send && ready_s;
   assign abort_s  = (!en) && (state_r != ST_IDLE);

   // Timer control: reload on every state entry so states chain without gaps
   always_comb begin
      timer_load_s  = 1'b0;
      timer_clear_s = 1'b0;
      timer_units_s = DOT_U;
      if (abort_s) begin
         timer_clear_s = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s && lookup_s.valid) begin
                  timer_load_s = 1'b1;
                  if (lookup_s.is_space) begin
                     timer_units_s = WORD_GAP_U;
                  end else begin
                     timer_units_s = lookup_s.code.pat[4] ? DASH_U : DOT_U;
                  end
               end else begin
                  timer_load_s = 1'b0;
               end
            end
            ST_MARK: begin
               if (timer_expired_s) begin
                  timer_load_s  = 1'b1;
                  timer_units_s = (remain_r > 3'd1) ? ELEM_GAP_U : CHAR_GAP_U;
               end else begin
                  timer_load_s = 1'b0;
               end
            end
            ST_ELEM_GAP: begin
               if (timer_expired_s) begin
                  timer_load_s  = 1'b1;
                  timer_units_s = tail_r[3] ? DASH_U : DOT_U;
               end else begin
                  timer_load_s = 1'b0;
               end
            end
            default: begin
               timer_load_s = 1'b0;
            end
         endcase
      end
   end

   morse_char_tx_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear_s),
      .load    (timer_load_s),
      .units   (timer_units_s),
      .expired (timer_expired_s)
   );

   // Transmit FSM with registered key/status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         tail_r    <= 4'b0000;
         remain_r  <= 3'd0;
         key_out_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         invalid_r <= 1'b0;
      end else begin
         done_r    <= 1'b0;
         invalid_r <= 1'b0;
         if (abort_s) begin
            state_r   <= ST_IDLE;
            key_out_r <= 1'b0;
            busy_r    <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (accept_s) begin
                     if (!lookup_s.valid) begin
                        invalid_r <= 1'b1;
                     end else if (lookup_s.is_space) begin
                        state_r   <= ST_WORD_GAP;
                        busy_r    <= 1'b1;
                        key_out_r <= 1'b0;
                     end else begin
                        state_r   <= ST_MARK;
                        tail_r    <= lookup_s.code.pat[3:0];
                        remain_r  <= lookup_s.code.len;
                        busy_r    <= 1'b1;
                        key_out_r <= 1'b1;
                     end
                  end
               end
               ST_MARK: begin
                  if (timer_expired_s) begin
                     key_out_r <= 1'b0;
                     state_r   <= (remain_r > 3'd1) ? ST_ELEM_GAP : ST_CHAR_GAP;
                  end
               end
               ST_ELEM_GAP: begin
                  if (timer_expired_s) begin
                     tail_r    <= {tail_r[2:0], 1'b0};
                     remain_r  <= remain_r - 3'd1;
                     key_out_r <= 1'b1;
                     state_r   <= ST_MARK;
                  end
               end
               ST_CHAR_GAP, ST_WORD_GAP: begin
                  if (timer_expired_s) begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end
               end
               default: begin
                  state_r   <= ST_IDLE;
                  key_out_r <= 1'b0;
                  busy_r    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.ready   = ready_s;
   assign bus.busy    = busy_r;
   assign bus.key_out = key_out_r;
   assign bus.done    = done_r;
   assign bus.invalid = invalid_r;

endmodule

// File: tb/tb_morse_char_tx.sv
// ---------------------------------------------------------------------------
// tb_morse_char_tx
// Bench for morse_char_tx with UNIT_CYCLES = 4. Expected key waveforms are
// expanded from dot/dash strings of the Morse alphabet.
// ---------------------------------------------------------------------------
module tb_morse_char_tx;

   localparam int U = 4;

   logic clk = 1'b0;
   logic rst;
   logic en;
   int   checks = 0;
   int   errors = 0;
   bit   exp_q[$];

   string tbl [36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-",
      ".....", "-....", "--...", "---..", "----."
   };

   morse_char_tx_if bus ();

   morse_char_tx #(.UNIT_CYCLES(U)) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Dot/dash string for a character: "" = unsupported, " " = word gap
   function automatic string morse_of(input logic [7:0] c);
      int v;
      v = int'(c);
      if (v >= 97 && v <= 122) v = v - 32;
      if (v >= 65 && v <= 90) return tbl[v - 65];
      if (v >= 48 && v <= 57) return tbl[26 + v - 48];
      if (v == 32) return " ";
      return "";
   endfunction

   // Per-cycle key level expected from the accepting edge to the last gap cycle
   task automatic build_wave(input string m);
      exp_q.delete();
      if (m == " ") begin
         repeat (7 * U) exp_q.push_back(1'b0);
      end else begin
         for (int i = 0; i < m.len(); i++) begin
            repeat ((m[i] == 8'h2D) ? 3 * U : U) exp_q.push_back(1'b1);
            repeat ((i == m.len() - 1) ? 3 * U : U) exp_q.push_back(1'b0);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      bus.send = 1'b0;
      bus.char_code = 8'h00;
      repeat (3) tick();
      checks++;
      if (bus.key_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.invalid !== 1'b0 || bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_values key=%b busy=%b done=%b inv=%b ready=%b required 0 0 0 0 1",
                  bus.key_out, bus.busy, bus.done, bus.invalid, bus.ready);
      end
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         checks++;
         if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.key_out !== 1'b0) begin
            errors++;
            $display("FAIL idle cycle=%0d ready=%b busy=%b key=%b required 1 0 0",
                     i, bus.ready, bus.busy, bus.key_out);
         end
      end
   endtask

   task automatic test_letters();
      logic [7:0] cs [2];
      cs[0] = 8'h45;
      cs[1] = 8'h61;
      for (int n = 0; n < 2; n++) begin
         build_wave(morse_of(cs[n]));
         bus.char_code = cs[n];
         bus.send = 1'b1;
         checks++;
         if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL letters_ready char=%h ready=%b required 1", cs[n], bus.ready);
         end
         tick();
         bus.send = 1'b0;
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.key_out !== exp_q[i] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
               errors++;
               $display("FAIL letters_wave char=%h cycle=%0d key=%b busy=%b done=%b required key=%b busy=1 done=0",
                        cs[n], i, bus.key_out, bus.busy, bus.done, exp_q[i]);
            end
            tick();
         end
         checks++;
         if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.key_out !== 1'b0 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL letters_done char=%h done=%b busy=%b key=%b ready=%b required 1 0 0 1",
                     cs[n], bus.done, bus.busy, bus.key_out, bus.ready);
         end
         tick();
         checks++;
         if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL letters_done_width char=%h done=%b required 0", cs[n], bus.done);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] cs [2];
      cs[0] = 8'h30;
      cs[1] = 8'h20;
      for (int n = 0; n < 2; n++) begin
         build_wave(morse_of(cs[n]));
         bus.char_code = cs[n];
         bus.send = 1'b1;
         checks++;
         if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready char=%h ready=%b required 1", cs[n], bus.ready);
         end
         tick();
         bus.send = 1'b0;
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.key_out !== exp_q[i] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
               errors++;
               $display("FAIL b2b_wave char=%h cycle=%0d key=%b busy=%b done=%b required key=%b busy=1 done=0",
                        cs[n], i, bus.key_out, bus.busy, bus.done, exp_q[i]);
            end
            tick();
         end
         checks++;
         if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.key_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done char=%h done=%b busy=%b key=%b required 1 0 0",
                     cs[n], bus.done, bus.busy, bus.key_out);
         end
      end
      tick();
   endtask

   task automatic test_invalid();
      bus.char_code = 8'h23;
      bus.send = 1'b1;
      tick();
      bus.send = 1'b0;
      checks++;
      if (bus.invalid !== 1'b1 || bus.key_out !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL invalid_pulse inv=%b key=%b ready=%b busy=%b required 1 0 1 0",
                  bus.invalid, bus.key_out, bus.ready, bus.busy);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++;
         if (bus.invalid !== 1'b0 || bus.done !== 1'b0 || bus.key_out !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_after cycle=%0d inv=%b done=%b key=%b busy=%b required 0 0 0 0",
                     i, bus.invalid, bus.done, bus.key_out, bus.busy);
         end
      end
   endtask

   task automatic test_ignore_busy();
      build_wave(morse_of(8'h45));
      bus.char_code = 8'h45;
      bus.send = 1'b1;
      tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (bus.key_out !== exp_q[i] || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore cycle=%0d key=%b ready=%b required key=%b ready=0",
                     i, bus.key_out, bus.ready, exp_q[i]);
         end
         bus.char_code = 8'h54;
         bus.send = (i < 6) ? 1'b1 : 1'b0;
         tick();
      end
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL busy_ignore_done done=%b required 1", bus.done);
      end
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++;
         if (bus.busy !== 1'b0 || bus.key_out !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_queued cycle=%0d busy=%b key=%b required 0 0",
                     i, bus.busy, bus.key_out);
         end
      end
   endtask

   // use_rst=1 aborts with reset (plus a same-edge send), else with en low
   task automatic test_abort(input bit use_rst);
      bus.char_code = 8'h54;
      bus.send = 1'b1;
      tick();
      bus.send = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.key_out !== 1'b1) begin
            errors++;
            $display("FAIL abort_dash rst=%0d cycle=%0d key=%b required 1", use_rst, i, bus.key_out);
         end
         if (i < 4) tick();
      end
      if (use_rst) begin
         rst = 1'b1;
         bus.char_code = 8'h45;
         bus.send = 1'b1;
      end else begin
         en = 1'b0;
      end
      tick();
      checks++;
      if (bus.key_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ready !== en) begin
         errors++;
         $display("FAIL abort_edge rst=%0d key=%b busy=%b done=%b ready=%b required 0 0 0 %b",
                  use_rst, bus.key_out, bus.busy, bus.done, bus.ready, en);
      end
      rst = 1'b0;
      en = 1'b1;
      bus.send = 1'b0;
      #1;
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready rst=%0d ready=%b required 1", use_rst, bus.ready);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++;
         if (bus.done !== 1'b0 || bus.key_out !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet rst=%0d cycle=%0d done=%b key=%b busy=%b required 0 0 0",
                     use_rst, i, bus.done, bus.key_out, bus.busy);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] bad [8];
      logic [7:0] c;
      string      m;
      bad = '{8'h23, 8'h2F, 8'h3A, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h2E};
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: c = 8'(65 + $urandom_range(0, 25));
            4, 5:       c = 8'(97 + $urandom_range(0, 25));
            6, 7:       c = 8'(48 + $urandom_range(0, 9));
            8:          c = 8'h20;
            default:    c = bad[$urandom_range(0, 7)];
         endcase
         m = morse_of(c);
         bus.char_code = c;
         bus.send = 1'b1;
         tick();
         bus.send = 1'b0;
         if (m == "") begin
            checks++;
            if (bus.invalid !== 1'b1 || bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
               errors++;
               $display("FAIL rand_invalid char=%h inv=%b busy=%b ready=%b required 1 0 1",
                        c, bus.invalid, bus.busy, bus.ready);
            end
            tick();
         end else begin
            build_wave(m);
            for (int i = 0; i < exp_q.size(); i++) begin
               checks++;
               if (bus.key_out !== exp_q[i] || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.invalid !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_wave char=%h cycle=%0d key=%b busy=%b done=%b required key=%b busy=1 done=0",
                           c, i, bus.key_out, bus.busy, bus.done, exp_q[i]);
               end
               tick();
            end
            checks++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.key_out !== 1'b0) begin
               errors++;
               $display("FAIL rand_done char=%h done=%b busy=%b key=%b required 1 0 0",
                        c, bus.done, bus.busy, bus.key_out);
            end
         end
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_letters();
      test_back_to_back();
      test_invalid();
      test_ignore_busy();
      test_abort(1'b1);
      test_abort(1'b0);
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/morse_char_tx.md
# morse_char_tx

Transmit-side counterpart of the button-to-character Morse path. Accepts one 8-bit ASCII character per handshake, looks up its International Morse code and drives `KEY_OUT` high and low with standard unit timing (dot 1, dash 3, element gap 1, character gap 3, word gap 7). Typical loads are an LED or buzzer enable. It sits beside the LCD driver and takes characters from the same `CHAR`/`WRITE`-style source.

## Interface
- `UNIT_CYCLES`, default 12_500_000: clock cycles per Morse unit (125 ms at 100 MHz). Must be ≥2.
- `CLK` in 1: system clock; all logic on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `EN` in 1: block enable. Low aborts any transmission.
- `CHAR` in 8: ASCII character. Sampled only on an accepting edge.
- `SEND` in 1: request. Accepted on an edge where `SEND && READY`.
- `READY` out 1: combinational, `EN && state==IDLE`.
- `BUSY` out 1: registered, high in any state other than IDLE.
- `KEY_OUT` out 1: registered Morse output; 1 = mark.
- `DONE` out 1: registered one-cycle pulse after the trailing gap completes.
- `INVALID` out 1: registered one-cycle pulse when an unsupported character is accepted.

## Operation
- Reset values: `KEY_OUT`=0, `BUSY`=0, `DONE`=0, `INVALID`=0, state IDLE, counter 0. `READY` follows `EN`.
- Supported characters:
  - A–Z; a–z folded to upper case.
  - 0–9.
  - 0x20 (space) = word gap.
  - Any other code is invalid.
- Lookup result is `{len[2:0], pat[4:0]}`. `pat` is left-aligned and MSB-first; 1 = dash, 0 = dot; `len` is 1..5. Example: 'A' = len 2, pat 01xxx.
- States and transitions:
  - IDLE: on accept of a valid letter or digit, register the code and go to MARK. Space goes to WORD_GAP. Invalid: pulse `INVALID`, stay in IDLE.
  - MARK: `KEY_OUT`=1 for 1 unit (dot) or 3 units (dash). When the counter expires, go to ELEM_GAP if elements remain, else CHAR_GAP.
  - ELEM_GAP: `KEY_OUT`=0 for 1 unit, shift the pattern, decrement the remaining count, go to MARK.
  - CHAR_GAP: 0 for 3 units, then pulse `DONE` and go to IDLE.
  - WORD_GAP: 0 for 7 units, then pulse `DONE` and go to IDLE.
- Counter: down-counter of width `$clog2(7*UNIT_CYCLES)`. Loaded with `n*UNIT_CYCLES-1` on state entry; the state exits when the counter reads 0.
- `SEND` while not READY is ignored, with no queuing. `CHAR` changes while BUSY have no effect.
- `EN` low in any non-IDLE state: next edge goes to IDLE with `KEY_OUT`=0. No `DONE` is produced. `INVALID` is unaffected.
- `RST` mid-operation: all outputs return to reset values on that edge. The in-flight character is discarded.
- `RST` and `SEND` on the same edge: `RST` wins.

## Timing
- Accept on edge k. From edge k, `KEY_OUT` and `BUSY` are high, so the first mark is visible 1 cycle after the accepting edge.
- Dot: exactly `UNIT_CYCLES` high cycles. Dash: exactly `3*UNIT_CYCLES`.
- Gaps are exact multiples of `UNIT_CYCLES`, with no extra cycles between states.
- `DONE` is high for the single cycle following the last gap cycle. `BUSY` falls and `READY` rises on that same edge.
- A new `SEND` can be accepted on the edge immediately after `DONE` is registered. This gives back-to-back throughput with zero dead cycles beyond the gap.
- Invalid character: `INVALID` is high for the one cycle after the accepting edge. `READY` stays high.

## Structure
- `morse_pkg`:
  - `morse_code_t` struct {len, pat}.
  - State enum `tx_state_t`.
  - Constants `DOT_U=1`, `DASH_U=3`, `ELEM_GAP_U=1`, `CHAR_GAP_U=3`, `WORD_GAP_U=7`.
  - Function `ascii_to_morse(input [7:0]) → {valid, is_space, morse_code_t}`. The decoder side shares this table for consistency.
- One sub-module, `morse_unit_timer`: down-counter with `load`/`units` inputs and an `expired` output, parameterised by `UNIT_CYCLES`.

## Test plan
Use `UNIT_CYCLES=4` for all scenarios.
- Reset and idle: after `RST`, with `EN`=1, expect `READY`=1, `BUSY`=0 and `KEY_OUT`=0 for 50 cycles.
- Send 'E' (0x45): `KEY_OUT` high 4 cycles, then low 12 cycles, then `DONE` for 1 cycle and `READY` high again.
- Send 'a' (0x61): `KEY_OUT` pattern high 4, low 4, high 12, low 12, then `DONE`, matching 'A' exactly.
- Send '0' (0x30) followed immediately by ' ' (0x20): five marks of 12 cycles separated by 4-cycle gaps, a 12-cycle character gap, then `DONE`. The space is accepted on the next edge, followed by 28 low cycles and then `DONE`.
- Send '#' (0x23): `INVALID` pulses for 1 cycle, `KEY_OUT` stays 0, `READY` stays 1, and no `DONE` is produced.
- Abort cases:
  - `SEND` 'T' while BUSY is ignored.
  - Assert `RST` on cycle 5 of a dash: `KEY_OUT`=0 on the next edge and no `DONE`.
  - Repeat with `EN` dropped instead of `RST`: same result.
